// File: rtl/instr_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WRITE_BACK sequencer for the Salamander-4 CPU.
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module instr_seq_ctrl #(
    parameter int OPC_W     = 3,
    parameter int RF_ADDR_W = 2,
    parameter int CE_W      = 4,
    parameter int FETCH_TMO = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 run_en,
    input  logic                 mem_rdy,
    input  logic                 pc_max,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step_req,
`endif
    input  logic [OPC_W-1:0]     op_code_in,
    input  logic [RF_ADDR_W-1:0] addr_in,
    input  logic [CE_W-1:0]      ce_in,
    input  logic                 acc_ce_in,
    output logic                 pc_inc,
    output logic                 id_ce,
    output logic [OPC_W-1:0]     op_code_q,
    output logic [RF_ADDR_W-1:0] addr_q,
    output logic                 alu_ce,
    output logic                 acc_ce,
    output logic [CE_W-1:0]      rf_ce,
    output logic [2:0]           state_o,
    output logic                 instr_done,
    output logic                 halted,
    output logic                 tmo_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

    logic [2:0]           state_q, state_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_err_q, tmo_err_d;
    logic [OPC_W-1:0]     op_code_d;
    logic [RF_ADDR_W-1:0] addr_d;
    logic [CE_W-1:0]      ce_q, ce_d;
    logic                 acc_q, acc_d;
    logic                 pc_max_q, pc_max_d;
    logic                 step_q, step_d;
    logic                 step_start;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_start = step_req;
`else
    assign step_start = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        op_code_d = op_code_q;
        addr_d    = addr_q;
        ce_d      = ce_q;
        acc_d     = acc_q;
        pc_max_d  = pc_max_q;
        step_d    = step_q;
        case (state_q)
            S_IDLE: begin
                if (run_en) begin
                    state_d = S_FETCH;
                    step_d  = 1'b0;
                end else if (step_start) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_rdy) begin
                    state_d   = S_DECODE;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_HALT;
                    tmo_err_d = 1'b1;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_code_d = op_code_in;
                addr_d    = addr_in;
                ce_d      = ce_in;
                acc_d     = acc_ce_in;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                // The PC only moves in WRITE_BACK, so its max flag is already final here;
                // registering it keeps pc_inc free of any input-to-output path.
                pc_max_d = pc_max;
                state_d  = S_WB;
            end
            S_WB: begin
                if (pc_max_q)    state_d = S_HALT;
                else if (step_q) state_d = S_IDLE;
                else if (run_en) state_d = S_FETCH;
                else             state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
            op_code_q <= '0;
            addr_q    <= '0;
            ce_q      <= '0;
            acc_q     <= 1'b0;
            pc_max_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
            op_code_q <= op_code_d;
            addr_q    <= addr_d;
            ce_q      <= ce_d;
            acc_q     <= acc_d;
            pc_max_q  <= pc_max_d;
            step_q    <= step_d;
        end
    end

    assign state_o    = state_q;
    assign id_ce      = (state_q == S_DECODE);
    assign alu_ce     = (state_q == S_EXEC);
    assign instr_done = (state_q == S_WB);
    assign acc_ce     = (state_q == S_WB) && acc_q;
    assign rf_ce      = (state_q == S_WB) ? ce_q : '0;
    assign pc_inc     = (state_q == S_WB) && !pc_max_q;
    assign halted     = (state_q == S_HALT);
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios plus randomized run
// against a cycle-level behavioural reference model.
module tb_instr_seq_ctrl;

    localparam int OPC_W     = 3;
    localparam int RF_ADDR_W = 2;
    localparam int CE_W      = 4;
    localparam int FETCH_TMO = 15;
`ifdef SEQ_SINGLE_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 run_en = 1'b0;
    logic                 mem_rdy = 1'b0;
    logic                 pc_max = 1'b0;
    logic                 step_req = 1'b0;
    logic [OPC_W-1:0]     op_in = '0;
    logic [RF_ADDR_W-1:0] addr_in = '0;
    logic [CE_W-1:0]      ce_in = '0;
    logic                 acc_in = 1'b0;

    logic                 pc_inc, id_ce, alu_ce, acc_ce, instr_done, halted, tmo_err;
    logic [OPC_W-1:0]     op_code_q;
    logic [RF_ADDR_W-1:0] addr_q;
    logic [CE_W-1:0]      rf_ce;
    logic [2:0]           state_o;

    always #5 clk = ~clk;

    instr_seq_ctrl #(
        .OPC_W(OPC_W), .RF_ADDR_W(RF_ADDR_W), .CE_W(CE_W), .FETCH_TMO(FETCH_TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .run_en(run_en), .mem_rdy(mem_rdy), .pc_max(pc_max),
`ifdef SEQ_SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .op_code_in(op_in), .addr_in(addr_in), .ce_in(ce_in), .acc_ce_in(acc_in),
        .pc_inc(pc_inc), .id_ce(id_ce), .op_code_q(op_code_q), .addr_q(addr_q),
        .alu_ce(alu_ce), .acc_ce(acc_ce), .rf_ce(rf_ce), .state_o(state_o),
        .instr_done(instr_done), .halted(halted), .tmo_err(tmo_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: state number as the encoding visible on state_o.
    int                   m_st;
    int                   m_wait;
    bit                   m_err;
    bit                   m_step;
    logic [OPC_W-1:0]     m_op;
    logic [RF_ADDR_W-1:0] m_addr;
    logic [CE_W-1:0]      m_ce;
    bit                   m_acc;

    task automatic m_reset();
        m_st = 0; m_wait = 0; m_err = 0; m_step = 0;
        m_op = '0; m_addr = '0; m_ce = '0; m_acc = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_next();
        case (m_st)
            0: begin
                if (run_en) begin m_st = 1; m_step = 0; end
                else if (STEP_ON && step_req) begin m_st = 1; m_step = 1; end
            end
            1: begin
                if (mem_rdy) begin
                    m_st = 2; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= FETCH_TMO) begin m_st = 5; m_err = 1; end
                end
            end
            2: begin
                m_op = op_in; m_addr = addr_in; m_ce = ce_in; m_acc = acc_in;
                m_st = 3;
            end
            3: m_st = 4;
            4: m_st = pc_max ? 5 : (m_step ? 0 : (run_en ? 1 : 0));
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        bit wb;
        wb = (m_st == 4);
        chk("state",      32'(state_o),    32'(m_st));
        chk("pc_inc",     32'(pc_inc),     32'(wb && !pc_max));
        chk("id_ce",      32'(id_ce),      32'(m_st == 2));
        chk("alu_ce",     32'(alu_ce),     32'(m_st == 3));
        chk("acc_ce",     32'(acc_ce),     32'(wb && m_acc));
        chk("rf_ce",      32'(rf_ce),      32'(wb ? m_ce : 4'b0));
        chk("instr_done", 32'(instr_done), 32'(wb));
        chk("halted",     32'(halted),     32'(m_st == 5));
        chk("tmo_err",    32'(tmo_err),    32'(m_err));
        chk("op_code_q",  32'(op_code_q),  32'(m_op));
        chk("addr_q",     32'(addr_q),     32'(m_addr));
    endtask

    task automatic tick();
        m_next();
        @(negedge clk);
        check_outputs();
    endtask

    // Called right after a falling edge; reset lands mid-cycle, away from the clock.
    task automatic do_reset();
        #2 rstn = 1'b0;
        m_reset();
        @(negedge clk);
        check_outputs();
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seq_exp [8];
        int dones;
        int halt_cnt;
        seq_exp = '{1, 2, 3, 4, 1, 2, 3, 4};
        m_reset();
        @(negedge clk);
        check_outputs();
        rstn = 1'b1;

        // Back-to-back instructions with no wait states.
        run_en = 1; mem_rdy = 1; pc_max = 0;
        op_in = 3'b010; addr_in = 2'b01; ce_in = 4'b0010; acc_in = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("seq", 32'(state_o), 32'(seq_exp[i]));
            if (state_o == 3'd4) begin
                chk("wb_rf_ce",  32'(rf_ce),  32'h2);
                chk("wb_acc_ce", 32'(acc_ce), 32'h1);
                chk("wb_pc_inc", 32'(pc_inc), 32'h1);
                chk("wb_op",     32'(op_code_q), 32'h2);
            end
        end

        // Three wait cycles in FETCH: retire on cycle 7.
        do_reset();
        run_en = 1; mem_rdy = 0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (instr_done) break;
            mem_rdy = (n >= 4);
        end
        chk("wait_latency", 32'(n), 32'd7);
        chk("wait_no_tmo",  32'(tmo_err), 32'd0);

        // Fetch timeout: HALT after exactly FETCH_TMO fetch cycles.
        do_reset();
        run_en = 1; mem_rdy = 0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (halted) break;
        end
        chk("tmo_cycles", 32'(n), 32'(FETCH_TMO + 1));
        for (int i = 0; i < 6; i++) begin
            run_en = i[0];
            mem_rdy = 1;
            tick();
        end
        chk("tmo_sticky_err", 32'(tmo_err), 32'd1);
        chk("tmo_held",       32'(state_o), 32'd5);

        // Last-address instruction: no pc_inc, then HALT.
        do_reset();
        run_en = 1; mem_rdy = 1; pc_max = 1; ce_in = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        chk("max_wb_done",   32'(instr_done), 32'd1);
        chk("max_wb_pc_inc", 32'(pc_inc),     32'd0);
        tick();
        chk("max_halt", 32'(state_o), 32'd5);
        pc_max = 0;

        // run_en dropped in EXEC: finish this instruction then idle.
        do_reset();
        run_en = 1; mem_rdy = 1; ce_in = 4'b0101; acc_in = 0;
        n = 0;
        while (n < 10 && state_o != 3'd3) begin tick(); n++; end
        chk("reach_exec", 32'(state_o), 32'd3);
        run_en = 0;
        tick();
        chk("drop_rf_ce", 32'(rf_ce), 32'h5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drop_no_inc", 32'(pc_inc), 32'd0);
        end
        chk("drop_idle", 32'(state_o), 32'd0);

        // Reset in EXEC aborts before write-back.
        run_en = 1; ce_in = 4'b1111; acc_in = 1;
        n = 0;
        while (n < 10 && state_o != 3'd3) begin tick(); n++; end
        chk("reach_exec2", 32'(state_o), 32'd3);
        do_reset();
        chk("abort_rf_ce", 32'(rf_ce), 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
        run_en = 0; step_req = 1;
        tick();
        step_req = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_done) dones++;
        end
        chk("step_dones", 32'(dones), 32'd1);
        chk("step_idle",  32'(state_o), 32'd0);
`endif

        // Randomized run with occasional resets and long memory stalls.
        do_reset();
        halt_cnt = 0;
        dones = 0;
        for (int i = 0; i < 3000; i++) begin
            run_en  = ($urandom_range(0, 9) < 8);
            mem_rdy = ((i % 500) > 470) ? 1'b0 : ($urandom_range(0, 9) < 6);
            if (m_st != 3 && m_st != 4) pc_max = ($urandom_range(0, 99) < 3);
            step_req = ($urandom_range(0, 9) == 0);
            op_in   = OPC_W'($urandom);
            addr_in = RF_ADDR_W'($urandom);
            ce_in   = CE_W'($urandom);
            acc_in  = 1'($urandom);
            halt_cnt = (m_st == 5) ? halt_cnt + 1 : 0;
            if ($urandom_range(0, 199) == 0 || halt_cnt > 8) begin
                do_reset();
                halt_cnt = 0;
            end else begin
                tick();
                if (instr_done) dones++;
            end
        end
        chk("rand_activity", 32'(dones > 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
